// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch front end. Owns the program counter, drives the
// instruction memory read port and presents {pc, instr} to the IF/ID
// register through a valid/ready handshake. EX redirects (taken branches
// and jumps) replace the sequential address for the cycle they are
// asserted. Halt freezes fetching while the debug loader owns the memory.
//
// The instruction memory returns data one cycle after a read_en=1 edge and
// holds it while read_en=0. Because of that, the presented instruction is
// simply the memory output. Only the PC of that word and a valid flag are
// tracked here.
//
// Optional feature:
//   FETCH_PERF_EN  When defined, fetch_count and stall_count are live
//                  32-bit wrapping counters. When undefined, both ports
//                  read 32'h0 and no counter flops exist.
//
// Parameters:
//   RESET_PC  PC of the first fetch after reset.
//   PC_STEP   Sequential PC increment in bytes.
//
// Ports:
//   clk          in   1   Clock; all state updates on posedge.
//   reset        in   1   Asynchronous, active-high reset.
//   imem_addr    out  32  Fetch address; bits [1:0] always 0.
//   imem_read_en out  1   Fetch request; memory captures on the same edge.
//   imem_data    in   32  Instruction memory data_out.
//   halt         in   1   Freeze fetching (debug program load).
//   redirect     in   1   Taken branch/jump from EX.
//   redirect_pc  in   32  Redirect target; bits [1:0] ignored.
//   if_valid     out  1   if_pc/if_instr carry a live instruction.
//   if_ready     in   1   IF/ID accepts when if_valid && if_ready.
//   if_pc        out  32  PC of the presented instruction.
//   if_instr     out  32  Presented instruction (equals imem_data).
//   fetch_count  out  32  Accepted-instruction count.
//   stall_count  out  32  Cycles with if_valid && !if_ready.
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    output logic        imem_read_en,
    input  logic [31:0] imem_data,
    input  logic        halt,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    // Next sequential fetch address.
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    // A fetched word is present on imem_data.
    logic        rsp_valid_q;
    logic        rsp_valid_d;
    // PC of the word present on imem_data.
    logic [31:0] rsp_pc_q;
    logic [31:0] rsp_pc_d;

    logic [31:0] tgt;
    logic [31:0] fetch_addr;
    logic        fire;
    logic        accept;

    always_comb begin
        tgt        = redirect_pc & ~32'h3;
        fetch_addr = redirect ? tgt : pc_q;
        // A new fetch is allowed when the slot is empty, when the current
        // word leaves this cycle, or when the current word is being
        // squashed by a redirect. Halt overrides everything.
        fire       = !halt && (redirect || !rsp_valid_q || if_ready);
        // Handshake completes only on a non-squashed word.
        accept     = rsp_valid_q && !redirect && if_ready;
    end

    always_comb begin
        pc_d        = pc_q;
        rsp_valid_d = rsp_valid_q;
        rsp_pc_d    = rsp_pc_q;

        if (fire) begin
            rsp_pc_d    = fetch_addr;
            rsp_valid_d = 1'b1;
            pc_d        = fetch_addr + STEP;   // wraps mod 2^32
        end else if (halt && redirect) begin
            // Remember the target so fetch resumes there once halt drops;
            // the in-flight word is squashed.
            pc_d        = tgt;
            rsp_valid_d = 1'b0;
        end else if (halt) begin
            if (accept) begin
                rsp_valid_d = 1'b0;
            end
        end
        // Remaining case is a plain stall: everything holds, and since
        // read_en is low the memory keeps presenting the same word.
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            rsp_valid_q <= 1'b0;
            rsp_pc_q    <= 32'h0;
        end else begin
            pc_q        <= pc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_pc_q    <= rsp_pc_d;
        end
    end

    assign imem_addr    = fetch_addr;
    assign imem_read_en = fire;
    assign if_valid     = rsp_valid_q && !redirect;
    assign if_pc        = rsp_pc_q;
    assign if_instr     = imem_data;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q;
    logic [31:0] fetch_count_d;
    logic [31:0] stall_count_q;
    logic [31:0] stall_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        stall_count_d = stall_count_q;
        if (if_valid && if_ready) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
        if (if_valid && !if_ready) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count_q <= 32'h0;
            stall_count_q <= 32'h0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`else
    assign fetch_count = 32'h0;
    assign stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic        imem_read_en;
    logic [31:0] imem_data;
    logic        halt;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] fetch_count;
    logic [31:0] stall_count;

    int checks;
    int fails;

    fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .imem_addr    (imem_addr),
        .imem_read_en (imem_read_en),
        .imem_data    (imem_data),
        .halt         (halt),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .if_valid     (if_valid),
        .if_ready     (if_ready),
        .if_pc        (if_pc),
        .if_instr     (if_instr),
        .fetch_count  (fetch_count),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: a word derived from its own address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory model: one-cycle read latency, output held while read_en=0.
    always @(posedge clk) begin
        if (imem_read_en) imem_data <= mem_word(imem_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        checks      = 0;
        fails       = 0;
        imem_data   = 32'h0;
        reset       = 1'b1;
        halt        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        if_ready    = 1'b1;

        // Reset state
        #2;
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_fcnt", fetch_count, 32'h0);
        check("rst_scnt", stall_count, 32'h0);

        // Release reset: first fetch at RESET_PC
        next_cycle(); reset = 1'b0; #1;
        check("c1_rd", 32'(imem_read_en), 32'd1);
        check("c1_addr", imem_addr, 32'h0);
        check("c1_valid", 32'(if_valid), 32'd0);

        next_cycle(); #1;
        check("c2_valid", 32'(if_valid), 32'd1);
        check("c2_pc", if_pc, 32'h0);
        check("c2_instr", if_instr, mem_word(32'h0));
        check("c2_addr", imem_addr, 32'h4);

        next_cycle(); #1;
        check("c3_pc", if_pc, 32'h4);
        check("c3_addr", imem_addr, 32'h8);

        // Stall three cycles at pc 8
        for (int i = 0; i < 3; i++) begin
            next_cycle(); if_ready = 1'b0; #1;
            check("stall_rd", 32'(imem_read_en), 32'd0);
            check("stall_valid", 32'(if_valid), 32'd1);
            check("stall_pc", if_pc, 32'h8);
            check("stall_instr", if_instr, mem_word(32'h8));
        end
        next_cycle(); if_ready = 1'b1; #1;
        check("unstall_pc", if_pc, 32'h8);
        check("unstall_addr", imem_addr, 32'hC);
        check("unstall_rd", 32'(imem_read_en), 32'd1);
`ifdef FETCH_PERF_EN
        check("scnt", stall_count, 32'd3);
        check("fcnt", fetch_count, 32'd2);
`else
        check("scnt_off", stall_count, 32'd0);
        check("fcnt_off", fetch_count, 32'd0);
`endif

        next_cycle(); #1;
        check("seq_pc12", if_pc, 32'hC);

        // Redirect while if_pc=16
        next_cycle(); redirect = 1'b1; redirect_pc = 32'h103; #1;
        check("redir_pc_cur", if_pc, 32'h10);
        check("redir_valid", 32'(if_valid), 32'd0);
        check("redir_addr", imem_addr, 32'h100);
        check("redir_rd", 32'(imem_read_en), 32'd1);

        next_cycle(); redirect = 1'b0; #1;
        check("tgt_valid", 32'(if_valid), 32'd1);
        check("tgt_pc", if_pc, 32'h100);
        check("tgt_instr", if_instr, mem_word(32'h100));

        next_cycle(); #1;
        check("tgt_pc2", if_pc, 32'h104);

        // Redirect to 20, then halt four cycles with word 20 pending
        redirect = 1'b1; redirect_pc = 32'h14;
        next_cycle(); redirect = 1'b0; halt = 1'b1; #1;
        check("h0_valid", 32'(if_valid), 32'd1);
        check("h0_pc", if_pc, 32'h14);
        check("h0_rd", 32'(imem_read_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            next_cycle(); #1;
            check("halt_valid", 32'(if_valid), 32'd0);
            check("halt_rd", 32'(imem_read_en), 32'd0);
        end
        next_cycle(); halt = 1'b0; #1;
        check("resume_rd", 32'(imem_read_en), 32'd1);
        check("resume_addr", imem_addr, 32'h18);
        next_cycle(); #1;
        check("resume_valid", 32'(if_valid), 32'd1);
        check("resume_pc", if_pc, 32'h18);
        check("resume_instr", if_instr, mem_word(32'h18));

        // Halt together with redirect: target captured, fetch waits
        next_cycle(); halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h200; #1;
        check("hr_valid", 32'(if_valid), 32'd0);
        check("hr_rd", 32'(imem_read_en), 32'd0);
        next_cycle(); redirect = 1'b0; #1;
        check("hr2_valid", 32'(if_valid), 32'd0);
        check("hr2_addr", imem_addr, 32'h200);
        next_cycle(); halt = 1'b0; #1;
        check("hr3_rd", 32'(imem_read_en), 32'd1);
        check("hr3_addr", imem_addr, 32'h200);
        next_cycle(); #1;
        check("hr4_pc", if_pc, 32'h200);

        // PC wrap at the top of the address space
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF; #1;
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        next_cycle(); redirect = 1'b0; #1;
        check("wrap_pc", if_pc, 32'hFFFF_FFFC);
        check("wrap_instr", if_instr, mem_word(32'hFFFF_FFFC));
        check("wrap_next", imem_addr, 32'h0);
        next_cycle(); #1;
        check("wrap_pc0", if_pc, 32'h0);

        // Reset asserted mid-stall
        if_ready = 1'b0;
        next_cycle(); #1;
        check("ms_valid", 32'(if_valid), 32'd1);
        reset = 1'b1; #1;
        check("ms_rst_valid", 32'(if_valid), 32'd0);
        check("ms_rst_pc", if_pc, 32'h0);
        check("ms_rst_scnt", stall_count, 32'h0);
        next_cycle(); reset = 1'b0; if_ready = 1'b1; #1;
        check("ms_rel_addr", imem_addr, 32'h0);
        check("ms_rel_rd", 32'(imem_read_en), 32'd1);
        check("ms_rel_valid", 32'(if_valid), 32'd0);
        next_cycle(); #1;
        check("ms_first_pc", if_pc, 32'h0);
        check("ms_first_valid", 32'(if_valid), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
